counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Sequencing controller for a binary up-counter: arms the counter on a start command, runs it from 0 up to a programmed terminal value, supports pause/resume and abort, and signals completion with a one-cycle pulse. It operates in one-shot or auto-reload mode. Interval timers and tick generators in the sequential library instantiate it wherever a bare free-running counter needs start/stop control and a terminal event.

## Interface
- WIDTH, 8, counter and terminal-value width
- PRE_W, 4, prescaler width; used only when COUNTER_CTRL_PRESCALE_EN is defined
- clk  input  1  clock, rising edge
- reset_n  input  1  synchronous, active-low reset; sampled on rising clk
- start  input  1  arm/restart; honoured only in IDLE or DONE
- pause  input  1  level; while high in RUN/PAUSE, counting is frozen
- abort  input  1  return to IDLE from any state; count cleared; no done pulse
- auto_reload  input  1  mode, latched at start: 1 = reload, 0 = one-shot
- load_val  input  WIDTH  terminal value, latched at start
- prescale  input  PRE_W  tick divider, latched at start (present only with macro)
- count  output  WIDTH  current count, registered
- busy  output  1  high in RUN or PAUSE
- paused  output  1  high in PAUSE
- done  output  1  one-cycle pulse on terminal event
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. reset_n=0 at a rising edge forces the following, with no other effect: state=IDLE, count=0, busy=0, paused=0, done=0, latched term/mode/prescale=0, prescaler=0.
- Priority per cycle: reset_n > abort > start > pause > tick.
- IDLE:
  - count=0.
  - start=1 → latch term=load_val and mode=auto_reload; count←0; go to RUN.
- RUN: on each tick:
  - If count==term: done←1 for one cycle.
    - reload: count←0, stay in RUN.
    - one-shot: go to DONE, count holds term.
  - Otherwise count←count+1.
  - pause=1 instead → go to PAUSE; count and prescaler hold; no increment that cycle.
- PAUSE:
  - Everything is frozen.
  - pause=0 → go to RUN. Counting resumes on the next tick.
- DONE:
  - busy=0 and count holds term.
  - start=1 → re-arm, as from IDLE.
- abort in any state → IDLE, count←0, done stays 0.
- start while busy is ignored. load_val and auto_reload changes while busy are ignored.
- Arithmetic: count never exceeds term. term=2^WIDTH−1 is legal, and the count reaches all-ones without overflow.
- term=0:
  - one-shot: done fires one tick after start.
  - reload: done fires on every tick.

## Timing
- start sampled at edge k → state=RUN and count=0 after edge k.
- Without prescaler, count=n after edge k+n.
- done=1 after edge k+term+1, for exactly one cycle.
- Reload period is term+1 ticks. done recurs every term+1 cycles.
- All outputs are registered. There are no combinational input-to-output paths.
- pause sampled high at edge j → count at edge j equals count at edge j−1.
- Terminal tick and pause in the same cycle: pause wins. done is deferred until the first tick after resume.
- Terminal tick and abort in the same cycle: abort wins, and done is never asserted.
- start and abort in the same cycle: abort wins, and the block stays in IDLE.

## Configuration
- COUNTER_CTRL_PRESCALE_EN defined:
  - The prescale port and an internal PRE_W-bit prescaler exist.
  - A tick occurs once every prescale+1 clocks while in RUN.
  - The prescaler clears on start, abort and reset. It freezes in PAUSE.
  - The first tick after start occurs prescale+1 cycles after RUN entry.
- COUNTER_CTRL_PRESCALE_EN undefined:
  - The prescale port is absent. Every RUN cycle is a tick.
  - Timing is as listed above.

## Test plan
- Reset: hold reset_n=0 for 2 cycles mid-RUN with count=5 → state=0, count=0, busy=0, done=0 after the reset edge.
- One-shot: load_val=3, auto_reload=0, start pulse:
  - count goes 0,1,2,3.
  - done pulse on the cycle after count=3.
  - state=3, count stays 3, busy=0.
- Reload: load_val=2, auto_reload=1 → count sequence 0,1,2,0,1,2…; done pulse every 3 cycles, coincident with count returning to 0.
- Pause/abort: load_val=10, pause high for 4 cycles at count=4:
  - count stays 4 and paused=1 during the pause.
  - After resume, done arrives 4 cycles late.
  - abort at count=7 → IDLE, count=0, no done.
- Boundaries:
  - load_val=0 one-shot → done 1 cycle after RUN entry.
  - load_val=255 with WIDTH=8 → reaches 255, then done, with no wrap.
  - start while busy is ignored.
- Macro defined, prescale=2, load_val=1 → count increments every 3 clocks; done 6 clocks after RUN entry.

Source files
------------

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if
//   Command/status bundle for the counter sequencing controller.
//   Optional feature macro: COUNTER_CTRL_PRESCALE_EN adds the prescale field.
//   Parameters : WIDTH - counter / terminal-value width
//                PRE_W - prescaler width (used only with the macro)
//   Commands   : start, pause, abort, auto_reload, load_val, [prescale]
//   Status     : count, busy, paused, done, state
//   Modports   : master - drives commands, observes status
//                slave  - the controller itself
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] prescale;
`else
  localparam int unused_pre_w = PRE_W;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             paused;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, pause, abort, auto_reload, load_val,
`ifdef COUNTER_CTRL_PRESCALE_EN
    output prescale,
`endif
    input  count, busy, paused, done, state
  );

  modport slave (
    input  start, pause, abort, auto_reload, load_val,
`ifdef COUNTER_CTRL_PRESCALE_EN
    input  prescale,
`endif
    output count, busy, paused, done, state
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Start/pause/abort sequencing around a binary up-counter that runs from 0
//   to a latched terminal value, in one-shot or auto-reload mode, with a
//   one-cycle done pulse on each terminal event. All outputs are registered.
//   Optional feature macro: COUNTER_CTRL_PRESCALE_EN (tick once every
//   prescale+1 RUN clocks instead of every RUN clock).
//   Ports:
//     clk     - clock, rising edge
//     reset_n - synchronous active-low reset
//     bus     - counter_seq_ctrl_if.slave (commands in, status out)
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | disarmed, count = 0, waiting for start
//   RUN    | counting one step per tick toward term
//   PAUSE  | pause held high, count and prescaler frozen
//   DONE   | one-shot finished, count holds term
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input logic               clk,
  input logic               reset_n,
  counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;
  logic             busy_q;
  logic             paused_q;
  logic             done_q;

  logic             tick;
  logic             at_term;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_d;

  // The prescaler only advances on non-paused RUN cycles (see the FSM), so
  // the first tick lands prescale+1 clocks after RUN entry.
  always_comb begin
    tick    = (presc_q == prescale_q);
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
  end
`else
  localparam int unused_pre_w = PRE_W;
  assign tick = 1'b1;
`endif

  assign at_term = (count_q == term_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      term_q     <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      prescale_q <= '0;
      presc_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q  <= S_IDLE;
        count_q  <= '0;
        busy_q   <= 1'b0;
        paused_q <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        presc_q  <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state_q    <= S_RUN;
              count_q    <= '0;
              term_q     <= bus.load_val;
              mode_q     <= bus.auto_reload;
              busy_q     <= 1'b1;
              paused_q   <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
              prescale_q <= bus.prescale;
              presc_q    <= '0;
`endif
            end
          end
          S_RUN, S_PAUSE: begin
            if (bus.pause) begin
              state_q  <= S_PAUSE;
              paused_q <= 1'b1;
            end else begin
              // Leaving PAUSE is itself a counting cycle: only the edges
              // where pause is sampled high lose a tick.
              state_q  <= S_RUN;
              paused_q <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
              presc_q  <= presc_d;
`endif
              if (tick) begin
                if (at_term) begin
                  done_q <= 1'b1;
                  if (mode_q) begin
                    count_q <= '0;
                  end else begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                  end
                end else begin
                  count_q <= count_q + WIDTH'(1);
                end
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count  = count_q;
  assign bus.busy   = busy_q;
  assign bus.paused = paused_q;
  assign bus.done   = done_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl
//   Drives directed and random command sequences into counter_seq_ctrl.
//   A reference model advances on each rising edge and queues the expected
//   outputs; a monitor on the falling edge pops and compares them.
//   The model tracks ticks elapsed since arming and derives count/done
//   arithmetically (modulo term+1 for reload, saturating for one-shot).
module tb_counter_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  typedef struct {
    int st;
    int cnt;
    bit busy;
    bit paused;
    bit done;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  counter_seq_ctrl_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  counter_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_st   = 0;
  int m_el   = 0;  // ticks since arming
  int m_rc   = 0;  // non-paused RUN clocks since arming
  int m_term = 0;
  int m_ps   = 0;
  bit m_mode = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   d;
    d = 1'b0;
    if (!reset_n) begin
      m_st = 0; m_el = 0; m_rc = 0; m_term = 0; m_ps = 0; m_mode = 0;
    end else if (bus.abort) begin
      m_st = 0; m_el = 0; m_rc = 0;
    end else if ((m_st == 0 || m_st == 3) && bus.start) begin
      m_term = int'(bus.load_val);
      m_mode = bus.auto_reload;
`ifdef COUNTER_CTRL_PRESCALE_EN
      m_ps = int'(bus.prescale);
`else
      m_ps = 0;
`endif
      m_el = 0; m_rc = 0; m_st = 1;
    end else if (m_st == 1 || m_st == 2) begin
      if (bus.pause) begin
        m_st = 2;
      end else begin
        m_st = 1;
        m_rc++;
        if (m_rc % (m_ps + 1) == 0) begin
          m_el++;
          if (m_mode) begin
            d = (m_el % (m_term + 1)) == 0;
          end else if (m_el == m_term + 1) begin
            d = 1'b1;
            m_st = 3;
          end
        end
      end
    end
    e.st     = m_st;
    e.cnt    = (m_st == 0) ? 0 : (m_st == 3) ? m_term :
               (m_mode ? (m_el % (m_term + 1)) : m_el);
    e.busy   = (m_st == 1 || m_st == 2);
    e.paused = (m_st == 2);
    e.done   = d;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.state !== 2'(e.st) || bus.count !== WIDTH'(e.cnt) ||
          bus.busy !== e.busy || bus.paused !== e.paused || bus.done !== e.done) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got state=%0d count=%0d busy=%0b paused=%0b done=%0b, expected state=%0d count=%0d busy=%0b paused=%0b done=%0b",
                 $time, bus.state, bus.count, bus.busy, bus.paused, bus.done,
                 e.st, e.cnt, e.busy, e.paused, e.done);
      end
    end
  end

  task automatic drive(input bit rst, input bit st, input bit pa, input bit ab,
                       input bit ar, input int lv, input int ps);
    @(negedge clk);
    #1;
    reset_n         = rst;
    bus.start       = st;
    bus.pause       = pa;
    bus.abort       = ab;
    bus.auto_reload = ar;
    bus.load_val    = WIDTH'(lv);
`ifdef COUNTER_CTRL_PRESCALE_EN
    bus.prescale    = PRE_W'(ps);
`else
    if (ps < 0) $display("negative prescale ignored");
`endif
  endtask

  task automatic go(input int lv, input bit ar, input int ps);
    drive(1, 1, 0, 0, ar, lv, ps);
  endtask

  // load_val/auto_reload wiggle while busy; the design must ignore them
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 0);
  endtask

  task automatic hold_pause(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_abort();
    drive(1, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    bit pa_lvl;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.auto_reload = 1'b0; bus.load_val = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
    bus.prescale = '0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // one-shot, term 3
    go(3, 0, 0);   idle(7);
    // reload, term 2
    go(2, 1, 0);   idle(10); do_abort(); idle(1);
    // pause 4 cycles at count 4, run to completion
    go(10, 0, 0);  idle(4); hold_pause(4); idle(10);
    // abort at count 7
    go(10, 0, 0);  idle(7); do_abort(); idle(3);
    // reset mid-run at count 5
    go(9, 0, 0);   idle(5);
    drive(0, 0, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0, 0); idle(2);
    // term 0 both modes
    go(0, 0, 0);   idle(3);
    go(0, 1, 0);   idle(4); do_abort();
    // full-scale terminal value
    go(255, 0, 0); idle(260);
    // start while busy
    go(20, 0, 0);  idle(3); go(5, 1, 0); idle(20);
    // terminal tick coincides with pause, then with abort
    go(2, 0, 0);   idle(2); hold_pause(1); idle(3);
    go(2, 0, 0);   idle(2); do_abort(); idle(2);
    // start and abort together
    drive(1, 1, 0, 1, 0, 4, 0); idle(2);
    // prescaled run (only meaningful with the prescaler built in)
    go(1, 0, 2);   idle(10);
    // random traffic
    pa_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) pa_lvl = ~pa_lvl;
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 7) == 0),
            pa_lvl,
            ($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6),
            $urandom_range(0, 3));
    end
    idle(3);
    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
